// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial pattern detector with a programmable pattern, selectable overlapping
// or non-overlapping detection and a saturating match counter.
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset (deassertion is
//                           synchronised internally with two flops)
//   data_in     in   1      serial data bit, first-received bit ends up at MSB
//   data_valid  in   1      data_in is sampled only when high
//   pat_load    in   1      load pat_in (and mask_in) as the new pattern
//   pat_in      in   PAT_W  new pattern value
//   mask_in     in   PAT_W  compare mask, 0 = don't care (SEQ_DETECT_MASK_EN only)
//   overlap_en  in   1      1 = overlapping, 0 = non-overlapping detection
//   clr_cnt     in   1      synchronous clear of match_cnt
//   match       out  1      one-cycle pulse per detected pattern
//   match_cnt   out  CNT_W  saturating match count
//   armed       out  1      at least PAT_W valid bits held since last flush
//
// Configuration macro
//   SEQ_DETECT_MASK_EN  adds mask_in and a mask register; compare becomes
//                       ((history ^ pattern) & mask) == 0.
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                PAT_W    = 5,
    parameter logic [PAT_W-1:0]  PAT_INIT = 5'b10010,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_in,
    input  logic              data_valid,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pat_in,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [PAT_W-1:0]  mask_in,
`endif
    input  logic              overlap_en,
    input  logic              clr_cnt,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              armed
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;

    logic [PAT_W-1:0]  r_hist;
    logic [PAT_W-1:0]  r_pat;
    logic [FILL_W-1:0] r_fill;
    logic              r_match;
    logic [CNT_W-1:0]  r_cnt;

    logic [PAT_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_inc;
    logic [PAT_W-1:0]  w_diff;
    logic              w_hit;

    // Reset assertion is immediate; release waits two clock edges so every
    // flop below leaves reset on the same, clean edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_W-1:0] r_mask;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mask <= '1;
        end else if (pat_load) begin
            r_mask <= mask_in;
        end
    end

    assign w_diff = (w_hist_nxt ^ r_pat) & r_mask;
`else
    assign w_diff = w_hist_nxt ^ r_pat;
`endif

    always_comb begin
        w_hist_nxt = {r_hist[PAT_W-2:0], data_in};
        w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : (r_fill + FILL_W'(1));
        // The completing bit counts toward the fill, so the compare uses the
        // post-shift history and the post-increment fill. A load in the same
        // cycle discards the bit and suppresses any match.
        w_hit      = data_valid && !pat_load
                     && (w_fill_inc == FILL_FULL) && (w_diff == '0);
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= PAT_INIT;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (pat_load) begin
                // History is left alone; clearing the fill alone guarantees
                // the next match is built from PAT_W post-load bits.
                r_pat  <= pat_in;
                r_fill <= '0;
            end else if (data_valid) begin
                r_hist <= w_hist_nxt;
                r_fill <= (w_hit && !overlap_en) ? '0 : w_fill_inc;
            end
        end
    end

    // Counter advances on the same edge that raises match, so match_cnt
    // already includes a pulse while that pulse is visible.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_hit && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign armed     = (r_fill == FILL_FULL);

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    localparam int            PW    = 5;
    localparam int            CW    = 8;
    localparam logic [PW-1:0] PINIT = 5'b10010;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          data_in    = 1'b0;
    logic          data_valid = 1'b0;
    logic          pat_load   = 1'b0;
    logic [PW-1:0] pat_in     = '0;
    logic          overlap_en = 1'b1;
    logic          clr_cnt    = 1'b0;
`ifdef SEQ_DETECT_MASK_EN
    logic [PW-1:0] mask_in    = '1;
`endif
    logic          match;
    logic [CW-1:0] match_cnt;
    logic          armed;

    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W    (PW),
        .PAT_INIT (PINIT),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
`ifdef SEQ_DETECT_MASK_EN
        .mask_in    (mask_in),
`endif
        .overlap_en (overlap_en),
        .clr_cnt    (clr_cnt),
        .match      (match),
        .match_cnt  (match_cnt),
        .armed      (armed)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a queue of the valid bits received since the last
    // flush (reset, load, or non-overlapping match), trimmed to PW entries.
    bit            mq[$];
    logic [PW-1:0] m_pat   = PINIT;
    logic [PW-1:0] m_mask  = '1;
    logic [PW-1:0] m_v;
    int            m_cnt   = 0;
    bit            m_match = 1'b0;
    bit            m_hit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pat   = PINIT;
            m_mask  = '1;
            m_cnt   = 0;
            m_match = 1'b0;
        end else begin
            m_hit = 1'b0;
            if (pat_load) begin
                m_pat = pat_in;
`ifdef SEQ_DETECT_MASK_EN
                m_mask = mask_in;
`endif
                mq.delete();
            end else if (data_valid) begin
                mq.push_back(data_in);
                if (mq.size() > PW) void'(mq.pop_front());
                if (mq.size() == PW) begin
                    m_v = '0;
                    foreach (mq[i]) m_v = {m_v[PW-2:0], mq[i]};
                    m_hit = (((m_v ^ m_pat) & m_mask) == '0);
                end
                if (m_hit && !overlap_en) mq.delete();
            end
            m_match = m_hit;
            if (clr_cnt) m_cnt = 0;
            else if (m_hit && (m_cnt < (2**CW - 1))) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_match", match, m_match);
            chk("cyc_match_cnt", match_cnt, m_cnt);
            chk("cyc_armed", armed, (mq.size() == PW));
        end
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic do_reset();
        data_valid = 1'b0;
        pat_load   = 1'b0;
        clr_cnt    = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic feed(input bit d, output bit m);
        data_valid = 1'b1;
        data_in    = d;
        pat_load   = 1'b0;
        clr_cnt    = 1'b0;
        @(negedge clk);
        m = match;
    endtask

    task automatic idle(input int n, output bit any);
        any        = 1'b0;
        data_valid = 1'b0;
        pat_load   = 1'b0;
        clr_cnt    = 1'b0;
        repeat (n) begin
            @(negedge clk);
            any |= match;
        end
    endtask

    task automatic load_pat(input logic [PW-1:0] p, input bit v, input bit d, output bit m);
        pat_load   = 1'b1;
        pat_in     = p;
        data_valid = v;
        data_in    = d;
        clr_cnt    = 1'b0;
        @(negedge clk);
        m = match;
        pat_load = 1'b0;
    endtask

    logic [7:0]  stream;
    logic [15:0] pv;
    bit          m;
    bit          any;
    int          npulse;

    initial begin
        do_reset();
        chk("reset_match", match, 0);
        chk("reset_cnt", match_cnt, 0);
        chk("reset_armed", armed, 0);
        chk_en = 1'b1;

        // Overlapping: 1,0,0,1,0,0,1,0 -> pulses after bits 5 and 8
        overlap_en = 1'b1;
        stream = 8'b10010010;
        pv = '0;
        for (int i = 0; i < 8; i++) begin
            feed(stream[7-i], m);
            pv[i] = m;
        end
        chk("ovl_pulses", pv, 16'h0090);
        chk("ovl_cnt", match_cnt, 2);
        idle(2, any);

        // Non-overlapping: single pulse after bit 5, armed drops
        do_reset();
        overlap_en = 1'b0;
        pv = '0;
        for (int i = 0; i < 8; i++) begin
            feed(stream[7-i], m);
            pv[i] = m;
            if (i == 4) chk("novl_armed_after_match", armed, 0);
        end
        chk("novl_pulses", pv, 16'h0010);
        chk("novl_cnt", match_cnt, 1);
        idle(2, any);

        // Valid gaps: 1,0,0 <3 idle> 1,0
        do_reset();
        overlap_en = 1'b1;
        pv = '0;
        feed(1'b1, m); pv[0] = m;
        feed(1'b0, m); pv[1] = m;
        feed(1'b0, m); pv[2] = m;
        idle(3, any);
        chk("gap_idle_no_match", any, 0);
        feed(1'b1, m); pv[3] = m;
        feed(1'b0, m); pv[4] = m;
        idle(1, any);
        chk("gap_pulses", pv, 16'h0010);
        chk("gap_pulse_one_cycle", any, 0);
        chk("gap_cnt", match_cnt, 1);

        // Load mid-stream (load wins over a simultaneous data bit)
        do_reset();
        pv = '0;
        feed(1'b1, m); pv[0] = m;
        feed(1'b1, m); pv[1] = m;
        load_pat(5'b11011, 1'b1, 1'b1, m); pv[2] = m;
        stream = 8'b11011000;
        for (int i = 0; i < 5; i++) begin
            feed(stream[7-i], m);
            pv[3+i] = m;
        end
        chk("load_pulses", pv, 16'h0080);
        idle(2, any);

        // Saturation and clear-vs-match priority
        do_reset();
        overlap_en = 1'b1;
        load_pat(5'b11111, 1'b0, 1'b0, m);
        npulse = 0;
        for (int i = 0; i < 300; i++) begin
            feed(1'b1, m);
            npulse += int'(m);
        end
        chk("sat_pulses", npulse, 296);
        chk("sat_cnt", match_cnt, 255);
        data_valid = 1'b1; data_in = 1'b1; clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr_with_match_pulse", match, 1);
        chk("clr_with_match_cnt", match_cnt, 0);
        idle(2, any);

        // Reset mid-sequence discards history
        do_reset();
        stream = 8'b10010000;
        for (int i = 0; i < 4; i++) feed(stream[7-i], m);
        do_reset();
        feed(1'b0, m);
        chk("rst_mid_no_match", m, 0);
        chk("rst_mid_armed0", armed, 0);
        feed(1'b1, m);
        feed(1'b0, m);
        feed(1'b0, m);
        chk("rst_mid_fill4_armed", armed, 0);
        feed(1'b1, m);
        chk("rst_mid_fill5_armed", armed, 1);
        chk("rst_mid_01001_no_match", m, 0);
        idle(2, any);

`ifdef SEQ_DETECT_MASK_EN
        do_reset();
        mask_in = 5'b11110;
        load_pat(5'b10011, 1'b0, 1'b0, m);
        stream = 8'b10010000;
        pv = '0;
        for (int i = 0; i < 5; i++) begin
            feed(stream[7-i], m);
            pv[i] = m;
        end
        chk("mask_pulses", pv, 16'h0010);
        idle(2, any);
        mask_in = '1;
`endif

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            data_valid = ($urandom_range(3) != 0);
            data_in    = 1'($urandom_range(1));
            pat_load   = ($urandom_range(59) == 0);
            case ($urandom_range(2))
                0:       pat_in = 5'b10010;
                1:       pat_in = 5'b11011;
                default: pat_in = PW'($urandom);
            endcase
`ifdef SEQ_DETECT_MASK_EN
            mask_in = ($urandom_range(1) != 0) ? '1 : PW'($urandom);
`endif
            clr_cnt = ($urandom_range(99) == 0);
            if ($urandom_range(31) == 0) overlap_en = 1'($urandom_range(1));
            @(negedge clk);
            if (i == 2000) do_reset();
        end
        idle(2, any);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
